pulse_rate_decoder: RTL

Receive-side counterpart of the rate divider: watches a single-cycle enable/tick stream on `PulseIn`, measures the spacing between ticks, and recovers the 2-bit speed code that produced it. It reports the code once two consecutive intervals agree, flags malformed intervals, and keeps a 4-bit tick count in step with the display counter. It sits on the board-test side, checking divider outputs and looping them back to LEDs/HEX.

---
 rtl/pulse_rate_decoder_if.sv | 25 ++
 rtl/pulse_rate_decoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pulse_rate_decoder_if.sv
// Tick-stream input and recovered-speed outputs of the pulse rate decoder.
// The master drives the tick stream; the slave is the decoder itself.
interface pulse_rate_decoder_if;
    logic       PulseIn;
    logic [1:0] SpeedOut;
    logic       Valid;
    logic       Error;
    logic [3:0] PulseCount;

    modport master (
        output PulseIn,
        input  SpeedOut,
        input  Valid,
        input  Error,
        input  PulseCount
    );

    modport slave (
        input  PulseIn,
        output SpeedOut,
        output Valid,
        output Error,
        output PulseCount
    );
endinterface

// File: rtl/pulse_rate_decoder.sv
// Measures the spacing of ticks on PulseIn and recovers the 2-bit speed code
// of the rate divider that produced them, locking once two intervals agree.
module pulse_rate_decoder #(
    parameter int unsigned CLOCK_FREQUENCY = 500,
    parameter int unsigned TOLERANCE       = 2
) (
    input  logic                 ClockIn,
    input  logic                 Reset,
    pulse_rate_decoder_if.slave  bus
);

    localparam int unsigned LIMIT = 4 * CLOCK_FREQUENCY + TOLERANCE + 1;
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAND,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] int_cnt_q;
    logic [1:0]       cand_q, cand_d;
    logic [1:0]       speed_q, speed_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic [3:0]       count_q;

    logic             tick;
    logic             at_limit;
    logic [31:0]      m_wide;
    logic             class_ok;
    logic [1:0]       class_code;

    assign tick     = bus.PulseIn;
    assign at_limit = (int_cnt_q == CNT_W'(LIMIT));
    assign m_wide   = 32'(int_cnt_q);

    // Distance is taken on the larger-minus-smaller side so it never wraps.
    function automatic logic near(input logic [31:0] m, input logic [31:0] target);
        logic [31:0] diff;
        diff = (m >= target) ? (m - target) : (target - m);
        return diff <= 32'(TOLERANCE);
    endfunction

    always_comb begin
        class_ok   = 1'b1;
        class_code = 2'd0;
        if (m_wide == 32'd1) begin
            class_code = 2'd0;
        end else if (near(m_wide, 32'(CLOCK_FREQUENCY))) begin
            class_code = 2'd1;
        end else if (near(m_wide, 32'(2 * CLOCK_FREQUENCY))) begin
            class_code = 2'd2;
        end else if (near(m_wide, 32'(4 * CLOCK_FREQUENCY))) begin
            class_code = 2'd3;
        end else begin
            class_ok = 1'b0;
        end
    end

    // NOTE: every signal gets its hold/default value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        speed_d = speed_q;
        valid_d = valid_q;
        error_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (class_ok) begin
                        state_d = CAND;
                        cand_d  = class_code;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                CAND: begin
                    if (!class_ok) begin
                        state_d = ARMED;
                        error_d = 1'b1;
                    end else if (class_code == cand_q) begin
                        state_d = LOCKED;
                        speed_d = cand_q;
                        valid_d = 1'b1;
                    end else begin
                        cand_d = class_code;
                    end
                end
                LOCKED: begin
                    if (!class_ok) begin
                        state_d = ARMED;
                        valid_d = 1'b0;
                        error_d = 1'b1;
                    end else if (class_code != speed_q) begin
                        state_d = CAND;
                        cand_d  = class_code;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && at_limit) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q   <= IDLE;
            int_cnt_q <= '0;
            cand_q    <= 2'd0;
            speed_q   <= 2'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            count_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            speed_q <= speed_d;
            valid_q <= valid_d;
            error_q <= error_d;
            if (tick) begin
                int_cnt_q <= CNT_W'(1);
                count_q   <= count_q + 4'd1;
            end else if (!at_limit) begin
                int_cnt_q <= int_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.SpeedOut   = speed_q;
    assign bus.Valid      = valid_q;
    assign bus.Error      = error_q;
    assign bus.PulseCount = count_q;

endmodule
